// File: rtl/mem_stage_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : mem_stage_ctrl
// Description : MEM pipeline stage controller. Non-memory ops pass straight
//               through to the WB registers in one cycle. Memory ops stall the
//               upstream stage and issue a single held request on the data
//               memory port. They complete when dmem_ready is seen. An access
//               that runs TIMEOUT_CYC cycles without dmem_ready is abandoned,
//               and a sticky error flag is raised.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   TIMEOUT_CYC        maximum number of ACCESS cycles before the access is
//                      abandoned (values below 1 behave as 1)
// Ports
//   clk                pipeline clock, all state updates on posedge
//   rst_n              asynchronous active-low reset
//   RegWrite_in        EX/MEM register-write enable
//   MemWrite_in        store request (wins over MemRead_in when both set)
//   MemRead_in         load request
//   call_in            call marker, passed through to WB
//   mem_to_reg_in      select load data for writeback
//   reg_rd_in   [3:0]  destination register
//   alu_result_in[15:0] ALU result, also the memory address
//   save_word_data_in[15:0] store data
//   ret_future_in      future ret_wb marker
//   dmem_req           memory request, held until accepted
//   dmem_we            1 = write, 0 = read
//   dmem_addr  [15:0]  memory address
//   dmem_wdata [15:0]  memory write data
//   dmem_rdata [15:0]  memory read data, valid with dmem_ready
//   dmem_ready         access complete this cycle
//   stall_out          upstream holds EX/MEM contents while high
//   RegWrite_wb        registered writeback enable
//   reg_rd_wb  [3:0]   registered writeback destination
//   wb_data    [15:0]  registered writeback data
//   call_wb            registered call marker
//   ret_wb             registered ret marker
//   mem_err            sticky timeout flag, cleared only by reset
// ============================================================================
module mem_stage_ctrl #(
    parameter int unsigned TIMEOUT_CYC = 15
) (
    input  logic        clk,
    input  logic        rst_n,
    // EX/MEM side
    input  logic        RegWrite_in,
    input  logic        MemWrite_in,
    input  logic        MemRead_in,
    input  logic        call_in,
    input  logic        mem_to_reg_in,
    input  logic [3:0]  reg_rd_in,
    input  logic [15:0] alu_result_in,
    input  logic [15:0] save_word_data_in,
    input  logic        ret_future_in,
    // data memory port
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [15:0] dmem_addr,
    output logic [15:0] dmem_wdata,
    input  logic [15:0] dmem_rdata,
    input  logic        dmem_ready,
    // pipeline control
    output logic        stall_out,
    // MEM/WB side
    output logic        RegWrite_wb,
    output logic [3:0]  reg_rd_wb,
    output logic [15:0] wb_data,
    output logic        call_wb,
    output logic        ret_wb,
    output logic        mem_err
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    // A zero timeout has no useful meaning, so it is clamped to one cycle.
    // This keeps the counter at least one bit wide.
    localparam int unsigned c_timeout_eff = (TIMEOUT_CYC < 1) ? 1 : TIMEOUT_CYC;
    localparam int unsigned c_cnt_w       = $clog2(c_timeout_eff + 1);

    localparam logic [c_cnt_w-1:0] c_cnt_max = c_cnt_w'(c_timeout_eff);
    localparam logic [c_cnt_w-1:0] c_cnt_one = c_cnt_w'(1);

    localparam logic [0:0] c_st_idle   = 1'b0;
    localparam logic [0:0] c_st_access = 1'b1;

    // ------------------------------------------------------------------------
    // Declarations
    // ------------------------------------------------------------------------
    logic [0:0]         r_state;
    logic [0:0]         w_next_state;

    // ACCESS-cycle counter. It is 1 in the first ACCESS cycle. It therefore
    // equals the number of ACCESS cycles spent so far, including the current one.
    logic [c_cnt_w-1:0] r_cnt;

    // Controls captured when a memory op is issued. The latched ALU result is
    // not duplicated here: dmem_addr already holds it for the whole access.
    logic               r_lat_regwrite;
    logic               r_lat_mem_to_reg;
    logic               r_lat_call;
    logic               r_lat_ret;
    logic [3:0]         r_lat_rd;

    logic               w_mem_op;
    logic               w_in_access;
    logic               w_cnt_at_limit;
    logic               w_complete;
    logic               w_timeout;

    logic               w_stall;
    logic               w_issue;
    logic               w_wb_pass;
    logic               w_wb_mem;

    // ------------------------------------------------------------------------
    // Shared decode
    // ------------------------------------------------------------------------
    assign w_mem_op       = MemRead_in | MemWrite_in;
    assign w_in_access    = (r_state == c_st_access);
    assign w_cnt_at_limit = (r_cnt == c_cnt_max);

    // Completion takes priority over the timeout. If ready arrives in the last
    // allowed cycle, the access completes normally.
    assign w_complete = w_in_access & dmem_ready;
    assign w_timeout  = w_in_access & ~dmem_ready & w_cnt_at_limit;

    // ------------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_st_idle: begin
                // dmem_ready is irrelevant here. Only the op type matters.
                if (w_mem_op) begin
                    w_next_state = c_st_access;
                end
            end
            c_st_access: begin
                if (w_complete || w_timeout) begin
                    w_next_state = c_st_idle;
                end
            end
            default: begin
                w_next_state = c_st_idle;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // FSM: output decode
    // ------------------------------------------------------------------------
    // w_issue   : start a memory access at the next edge
    // w_wb_pass : WB loads the live EX/MEM inputs (non-memory op)
    // w_wb_mem  : WB loads the latched controls (access completes)
    // When none of these is set, WB takes a bubble.
    always_comb begin
        w_stall   = 1'b0;
        w_issue   = 1'b0;
        w_wb_pass = 1'b0;
        w_wb_mem  = 1'b0;
        case (r_state)
            c_st_idle: begin
                if (w_mem_op) begin
                    w_stall = 1'b1;
                    w_issue = 1'b1;
                end else begin
                    w_wb_pass = 1'b1;
                end
            end
            c_st_access: begin
                if (dmem_ready) begin
                    w_wb_mem = 1'b1;
                end else if (!w_cnt_at_limit) begin
                    w_stall = 1'b1;
                end
                // In the timeout cycle the stall is released. The upstream
                // then moves on, and the abandoned op is dropped.
            end
            default: begin
                w_stall = 1'b0;
            end
        endcase
    end

    // Held-in-reset logic must not freeze the upstream pipeline.
    assign stall_out = rst_n & w_stall;

    // ------------------------------------------------------------------------
    // ACCESS cycle counter
    // ------------------------------------------------------------------------
    // The counter leaves ACCESS no later than the cycle in which it equals
    // c_cnt_max, so it can never wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (w_issue) begin
            r_cnt <= c_cnt_one;
        end else if (w_complete || w_timeout) begin
            r_cnt <= '0;
        end else if (w_in_access) begin
            r_cnt <= r_cnt + c_cnt_one;
        end
    end

    // ------------------------------------------------------------------------
    // Memory request registers
    // ------------------------------------------------------------------------
    // These registers are loaded once at issue and held for the whole access.
    // They return to zero when the access ends.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dmem_req   <= 1'b0;
            dmem_we    <= 1'b0;
            dmem_addr  <= '0;
            dmem_wdata <= '0;
        end else if (w_issue) begin
            dmem_req   <= 1'b1;
            // A simultaneous read+write request is treated as a write.
            dmem_we    <= MemWrite_in;
            dmem_addr  <= alu_result_in;
            dmem_wdata <= save_word_data_in;
        end else if (w_complete || w_timeout) begin
            dmem_req   <= 1'b0;
            dmem_we    <= 1'b0;
            dmem_addr  <= '0;
            dmem_wdata <= '0;
        end
    end

    // ------------------------------------------------------------------------
    // Latched writeback controls for the in-flight memory op
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lat_regwrite   <= 1'b0;
            r_lat_mem_to_reg <= 1'b0;
            r_lat_call       <= 1'b0;
            r_lat_ret        <= 1'b0;
            r_lat_rd         <= '0;
        end else if (w_issue) begin
            r_lat_regwrite   <= RegWrite_in;
            r_lat_mem_to_reg <= mem_to_reg_in;
            r_lat_call       <= call_in;
            r_lat_ret        <= ret_future_in;
            r_lat_rd         <= reg_rd_in;
        end
    end

    // ------------------------------------------------------------------------
    // MEM/WB registers
    // ------------------------------------------------------------------------
    // A bubble clears only the qualifying controls. reg_rd_wb and wb_data keep
    // their last values, which are meaningless while RegWrite_wb is low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            RegWrite_wb <= 1'b0;
            reg_rd_wb   <= '0;
            wb_data     <= '0;
            call_wb     <= 1'b0;
            ret_wb      <= 1'b0;
        end else if (w_wb_pass) begin
            RegWrite_wb <= RegWrite_in;
            reg_rd_wb   <= reg_rd_in;
            wb_data     <= alu_result_in;
            call_wb     <= call_in;
            ret_wb      <= ret_future_in;
        end else if (w_wb_mem) begin
            RegWrite_wb <= r_lat_regwrite;
            reg_rd_wb   <= r_lat_rd;
            wb_data     <= r_lat_mem_to_reg ? dmem_rdata : dmem_addr;
            call_wb     <= r_lat_call;
            ret_wb      <= r_lat_ret;
        end else begin
            RegWrite_wb <= 1'b0;
            call_wb     <= 1'b0;
            ret_wb      <= 1'b0;
        end
    end

    // ------------------------------------------------------------------------
    // Sticky timeout flag
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_err <= 1'b0;
        end else if (w_timeout) begin
            mem_err <= 1'b1;
        end
    end

endmodule
`default_nettype wire
